// File: rtl/fxp_pkg.sv
// Shared constants, state encoding and width helpers for the fixed-point MAC family.
// Behaviour is selected by the FXP_MAC_ROUND_EN macro in fxp_sat_quant.
package fxp_pkg;

  localparam int WIDTH_DEF = 23;
  localparam int FRAC_DEF  = 14;
  localparam int GUARD_DEF = 6;

  typedef enum logic [1:0] {
    st_acc  = 2'd0,
    st_last = 2'd1,
    st_out  = 2'd2
  } state_t;

  function automatic int acc_w(input int width, input int guard);
    return 2 * width + guard;
  endfunction

  // Symmetric limits: the most negative two's complement code is excluded.
  function automatic longint sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int width);
    return -sat_max(width);
  endfunction

endpackage

// File: rtl/fxp_sat_quant.sv
// Combinational accumulator-to-word quantiser with symmetric saturation.
// FXP_MAC_ROUND_EN defined: round-half-up before the shift; otherwise truncate toward -inf.
module fxp_sat_quant
  import fxp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int ACC_W = acc_w(WIDTH_DEF, GUARD_DEF)
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic signed [WIDTH-1:0] q,
  output logic                    ovf
);

  localparam logic signed [ACC_W:0] QMAX = (ACC_W + 1)'(sat_max(WIDTH));
  localparam logic signed [ACC_W:0] QMIN = (ACC_W + 1)'(sat_min(WIDTH));
`ifdef FXP_MAC_ROUND_EN
  localparam logic signed [ACC_W:0] RND_HALF =
    {{(ACC_W + 1 - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};
`endif

  logic signed [ACC_W:0] ext_s;
  logic signed [ACC_W:0] rnd_s;
  logic signed [ACC_W:0] shf_s;

  // One extra headroom bit so the rounding add can never wrap.
  always_comb begin
    ext_s = {sum[ACC_W-1], sum};
`ifdef FXP_MAC_ROUND_EN
    rnd_s = ext_s + RND_HALF;
`else
    rnd_s = ext_s;
`endif
    shf_s = rnd_s >>> FRAC;
    q     = shf_s[WIDTH-1:0];
    ovf   = 1'b0;
    if (shf_s > QMAX) begin
      q   = QMAX[WIDTH-1:0];
      ovf = 1'b1;
    end else if (shf_s < QMIN) begin
      q   = QMIN[WIDTH-1:0];
      ovf = 1'b1;
    end else begin
      q   = shf_s[WIDTH-1:0];
      ovf = 1'b0;
    end
  end

endmodule

// File: rtl/fxp_mac_sat.sv
// Streaming signed fixed-point multiply-accumulate with symmetric saturation.
// Rounding mode follows the FXP_MAC_ROUND_EN macro (see fxp_sat_quant).
module fxp_mac_sat
  import fxp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int GUARD = GUARD_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] in_a,
  input  logic signed [WIDTH-1:0] in_b,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_ovf,
  output logic [GUARD:0]          out_count,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int PW    = 2 * WIDTH;
  localparam int ACC_W = acc_w(WIDTH, GUARD);
  localparam logic [GUARD:0]       CNT_ONE  = {{GUARD{1'b0}}, 1'b1};
  localparam logic [GUARD:0]       CNT_ZERO = {(GUARD + 1){1'b0}};
  localparam logic signed [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
  localparam logic signed [PW-1:0]    P_ZERO   = {PW{1'b0}};

  state_t                  state_r, state_n;
  logic                    in_ready_r;
  logic signed [PW-1:0]    p_r;
  logic                    p_valid_r;
  logic signed [ACC_W-1:0] acc_r;
  logic [GUARD:0]          count_r;
  logic signed [WIDTH-1:0] out_data_r;
  logic                    out_ovf_r;
  logic [GUARD:0]          out_count_r;
  logic                    out_valid_r;

  logic                    hs_s;
  logic signed [PW-1:0]    prod_s;
  logic signed [ACC_W-1:0] pext_s;
  logic signed [ACC_W-1:0] sum_s;
  logic signed [WIDTH-1:0] q_s;
  logic                    ovf_s;

  assign in_ready  = in_ready_r;
  assign out_data  = out_data_r;
  assign out_ovf   = out_ovf_r;
  assign out_count = out_count_r;
  assign out_valid = out_valid_r;

  // Handshake, full-precision product and running sum including the pending product.
  always_comb begin
    hs_s   = in_valid & in_ready_r;
    prod_s = PW'(in_a) * PW'(in_b);
    pext_s = {{GUARD{p_r[PW-1]}}, p_r};
    if (p_valid_r) begin
      sum_s = acc_r + pext_s;
    end else begin
      sum_s = acc_r;
    end
  end

  fxp_sat_quant #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_quant (
    .sum (sum_s),
    .q   (q_s),
    .ovf (ovf_s)
  );

  // Next-state decode.
  always_comb begin
    state_n = state_r;
    case (state_r)
      st_acc: begin
        if (hs_s && in_last) begin
          state_n = st_last;
        end else begin
          state_n = st_acc;
        end
      end
      st_last: state_n = st_out;
      st_out: begin
        if (out_ready) begin
          state_n = st_acc;
        end else begin
          state_n = st_out;
        end
      end
      default: state_n = st_acc;
    endcase
  end

  // State register, product pipeline, accumulator and registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= st_acc;
      in_ready_r  <= 1'b0;
      p_r         <= P_ZERO;
      p_valid_r   <= 1'b0;
      acc_r       <= ACC_ZERO;
      count_r     <= CNT_ZERO;
      out_data_r  <= {WIDTH{1'b0}};
      out_ovf_r   <= 1'b0;
      out_count_r <= CNT_ZERO;
      out_valid_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      // Decoded from next state so in_ready stays a pure state flop.
      in_ready_r <= (state_n == st_acc);
      p_valid_r  <= 1'b0;
      if (hs_s) begin
        p_r       <= prod_s;
        p_valid_r <= 1'b1;
        count_r   <= count_r + CNT_ONE;
      end
      case (state_r)
        st_acc: acc_r <= sum_s;
        st_last: begin
          acc_r       <= sum_s;
          out_data_r  <= q_s;
          out_ovf_r   <= ovf_s;
          out_count_r <= count_r;
          out_valid_r <= 1'b1;
        end
        st_out: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            acc_r       <= ACC_ZERO;
            count_r     <= CNT_ZERO;
          end
        end
        default: acc_r <= ACC_ZERO;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_mac_sat.sv
// Directed, table-driven bench for fxp_mac_sat (expectations honour FXP_MAC_ROUND_EN).
module tb_fxp_mac_sat;

  logic               clk;
  logic               rst_n;
  logic signed [22:0] in_a;
  logic signed [22:0] in_b;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic signed [22:0] out_data;
  logic               out_ovf;
  logic [6:0]         out_count;
  logic               out_valid;
  logic               out_ready;

  int checks;
  int failures;

`ifdef FXP_MAC_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  typedef struct {
    logic signed [22:0] a;
    logic signed [22:0] b;
    longint             exp_d;
    logic               exp_o;
  } vec_t;

  vec_t vecs[10];

  fxp_mac_sat dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Present one pair and return at the negedge after it was accepted.
  task automatic push(input logic signed [22:0] a, input logic signed [22:0] b, input logic last);
    int n;
    n = 0;
    in_a = a; in_b = b; in_valid = 1'b1; in_last = last;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Wait (bounded) for a result, compare it and consume it.
  task automatic take(input string name, input longint d, input logic o, input int cnt);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_data"}, out_data, d);
    chk({name, "_ovf"}, out_ovf, o);
    chk({name, "_count"}, out_count, cnt);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_released"}, out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0;
    vecs[0] = '{a: 23'sd24576,    b: 23'sd32768, exp_d: 49152,    exp_o: 1'b0};
    vecs[1] = '{a: 23'sd3276800,  b: 23'sd32768, exp_d: 4194303,  exp_o: 1'b1};
    vecs[2] = '{a: -23'sd3276800, b: 23'sd32768, exp_d: -4194303, exp_o: 1'b1};
    vecs[3] = '{a: 23'sd1,        b: 23'sd8192,  exp_d: (RND != 0) ? 1 : 0,  exp_o: 1'b0};
    vecs[4] = '{a: -23'sd1,       b: 23'sd8192,  exp_d: (RND != 0) ? 0 : -1, exp_o: 1'b0};
    vecs[5] = '{a: 23'sd0,        b: 23'sd4194303, exp_d: 0,      exp_o: 1'b0};
    vecs[6] = '{a: -23'sd16384,   b: 23'sd16384, exp_d: -16384,   exp_o: 1'b0};
    vecs[7] = '{a: -23'sd4194304, b: -23'sd4194304, exp_d: 4194303, exp_o: 1'b1};
    vecs[8] = '{a: 23'sd4194303,  b: 23'sd16384, exp_d: 4194303,  exp_o: 1'b0};
    vecs[9] = '{a: -23'sd4194304, b: 23'sd16384, exp_d: -4194303, exp_o: 1'b1};

    rst_n = 1'b0; in_a = 23'sd0; in_b = 23'sd0;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_out_count", out_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Single-term frames with exact two-edge latency.
    for (int i = 0; i < 10; i++) begin
      push(vecs[i].a, vecs[i].b, 1'b1);
      chk($sformatf("vec%0d_lat_early", i), out_valid, 0);
      chk($sformatf("vec%0d_ready_low", i), in_ready, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_lat_on", i), out_valid, 1);
      take($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_o, 1);
    end

    // Four-term frame at one pair per cycle, then back-to-back frame.
    for (int i = 0; i < 4; i++) push(23'sd16384, 23'sd16384, (i == 3) ? 1'b1 : 1'b0);
    take("frame4", 65536, 1'b0, 4);
    chk("b2b_ready", in_ready, 1);
    push(23'sd16384, -23'sd8192, 1'b0);
    push(23'sd16384, -23'sd8192, 1'b1);
    take("frame2", -16384, 1'b0, 2);

    // Output stall with upstream waiting: nothing consumed, outputs frozen.
    push(23'sd24576, 23'sd32768, 1'b1);
    @(negedge clk);
    in_a = 23'sd16384; in_b = 23'sd16384; in_valid = 1'b1; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_valid", k), out_valid, 1);
      chk($sformatf("stall%0d_data", k), out_data, 49152);
      chk($sformatf("stall%0d_count", k), out_count, 1);
      chk($sformatf("stall%0d_in_ready", k), in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall_release_ready", in_ready, 1);
    push(23'sd16384, 23'sd16384, 1'b1);
    take("after_stall", 16384, 1'b0, 1);

    // Reset for one cycle after three terms of a frame.
    for (int i = 0; i < 3; i++) push(23'sd16384, 23'sd16384, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_data", out_data, 0);
    chk("midrst_ovf", out_ovf, 0);
    chk("midrst_count", out_count, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    push(23'sd16384, 23'sd16384, 1'b1);
    take("post_midrst", 16384, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
